mode7_line_setup: RTL and testbench

- Per-scanline setup engine for the mode-7 floor renderer. Runs during horizontal blanking.
- Takes the four frame-constant frustum corners (a, b, c, d in texture space) and the per-line perspective factor 1/(y-240).
- Produces the start texture coordinate and per-pixel u/v strides for the next scanline. The downstream pixel stepper loads these at x=0.
- Shares a single signed multiplier across six sequential products to fit the iCE40.

---
 rtl/mode7_line_setup.sv | 216 +++++++++++++++++++++
 tb/tb_mode7_line_setup.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mode7_line_setup.sv
// Per-scanline mode-7 setup: left-edge texture coordinate and per-pixel u/v strides from the frustum corners.
// Optional MODE7_SETUP_PIPE_MUL_EN registers the shared multiplier output (2 cycles per product, latency 13).
module mode7_line_setup #(
   parameter int CW         = 29,
   parameter int OW         = 33,
   parameter int STRIDE_MUL = 102
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic [CW-1:0] a_u_i,
   input  logic [CW-1:0] a_v_i,
   input  logic [CW-1:0] b_u_i,
   input  logic [CW-1:0] b_v_i,
   input  logic [CW-1:0] c_u_i,
   input  logic [CW-1:0] c_v_i,
   input  logic [CW-1:0] d_u_i,
   input  logic [CW-1:0] d_v_i,
   input  logic [16:0]   one_over_y_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [OW-1:0] line_u_o,
   output logic [OW-1:0] line_v_o,
   output logic [OW-1:0] u_stride_o,
   output logic [OW-1:0] v_stride_o
);

   // state | meaning
   // IDLE  | waiting for start; outputs hold the last line
   // LU    | left_u  = c_u + ((a_u - c_u) >>> 16) * 1/y
   // LV    | left_v  = c_v + ((a_v - c_v) >>> 16) * 1/y
   // RU    | right_u = d_u + ((b_u - d_u) >>> 16) * 1/y
   // RV    | right_v = d_v + ((b_v - d_v) >>> 16) * 1/y
   // SU    | u_stride = ((right_u - left_u) * STRIDE_MUL) >>> 16
   // SV    | v_stride likewise; all outputs load on leaving SV
   // DONE  | done pulse, back to IDLE

   localparam int SW = 36;
   localparam int MW = 45;
   localparam int FB = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_LU, S_LV, S_RU, S_RV, S_SU, S_SV, S_DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] a_u_q, a_v_q, b_u_q, b_v_q, c_u_q, c_v_q, d_u_q, d_v_q;
   logic [16:0]   oy_q;
   logic [SW-1:0] left_u_q, left_v_q, right_u_q, right_v_q;
   logic [OW-1:0] su_q;
   logic          busy_q, done_q;
   logic [OW-1:0] line_u_q, line_v_q, u_stride_q, v_stride_q;

   logic signed [CW-1:0] hi_s, lo_s;
   logic signed [CW:0]   diff_s, step_s;
   logic signed [SW-1:0] span_l_s, span_r_s;
   logic                 line_st;
   logic signed [MW-1:0] mul_a, mul_b, mul_p, prod;
   logic signed [SW-1:0] sum_d;
   logic signed [OW-1:0] stride_d;
   logic                 adv;

`ifdef MODE7_SETUP_PIPE_MUL_EN
   logic signed [MW-1:0] mul_q;
   logic                 phase_q;
   assign adv  = phase_q;
   assign prod = mul_q;
`else
   assign adv  = 1'b1;
   assign prod = mul_p;
`endif

   // Operand selection for the one shared multiplier; lo_s is also the base corner of the line sums.
   always_comb begin
      hi_s     = $signed(a_u_q);
      lo_s     = $signed(c_u_q);
      span_l_s = $signed(left_u_q);
      span_r_s = $signed(right_u_q);
      line_st  = 1'b1;
      case (state_q)
         S_LV: begin
            hi_s = $signed(a_v_q);
            lo_s = $signed(c_v_q);
         end
         S_RU: begin
            hi_s = $signed(b_u_q);
            lo_s = $signed(d_u_q);
         end
         S_RV: begin
            hi_s = $signed(b_v_q);
            lo_s = $signed(d_v_q);
         end
         S_SU: line_st = 1'b0;
         S_SV: begin
            line_st  = 1'b0;
            span_l_s = $signed(left_v_q);
            span_r_s = $signed(right_v_q);
         end
         default: ;
      endcase

      diff_s = {hi_s[CW-1], hi_s} - {lo_s[CW-1], lo_s};
      step_s = diff_s >>> FB;

      if (line_st) begin
         mul_a = MW'(step_s);
         mul_b = MW'($signed({1'b0, oy_q}));
      end else begin
         mul_a = MW'(span_r_s) - MW'(span_l_s);
         mul_b = MW'(STRIDE_MUL);
      end
      // Only the low MW bits of the product are ever needed, so an MW x MW multiply suffices.
      mul_p = mul_a * mul_b;

      sum_d    = SW'(lo_s) + SW'(prod);
      stride_d = OW'(prod >>> FB);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         a_u_q      <= '0;
         a_v_q      <= '0;
         b_u_q      <= '0;
         b_v_q      <= '0;
         c_u_q      <= '0;
         c_v_q      <= '0;
         d_u_q      <= '0;
         d_v_q      <= '0;
         oy_q       <= '0;
         left_u_q   <= '0;
         left_v_q   <= '0;
         right_u_q  <= '0;
         right_v_q  <= '0;
         su_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         line_u_q   <= '0;
         line_v_q   <= '0;
         u_stride_q <= '0;
         v_stride_q <= '0;
`ifdef MODE7_SETUP_PIPE_MUL_EN
         mul_q      <= '0;
         phase_q    <= 1'b0;
`endif
      end else begin
`ifdef MODE7_SETUP_PIPE_MUL_EN
         mul_q <= mul_p;
         if (state_q inside {S_LU, S_LV, S_RU, S_RV, S_SU, S_SV})
            phase_q <= ~phase_q;
         else
            phase_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  a_u_q   <= a_u_i;
                  a_v_q   <= a_v_i;
                  b_u_q   <= b_u_i;
                  b_v_q   <= b_v_i;
                  c_u_q   <= c_u_i;
                  c_v_q   <= c_v_i;
                  d_u_q   <= d_u_i;
                  d_v_q   <= d_v_i;
                  oy_q    <= one_over_y_i;
                  busy_q  <= 1'b1;
                  state_q <= S_LU;
               end
            end
            S_LU: if (adv) begin
               left_u_q <= sum_d;
               state_q  <= S_LV;
            end
            S_LV: if (adv) begin
               left_v_q <= sum_d;
               state_q  <= S_RU;
            end
            S_RU: if (adv) begin
               right_u_q <= sum_d;
               state_q   <= S_RV;
            end
            S_RV: if (adv) begin
               right_v_q <= sum_d;
               state_q   <= S_SU;
            end
            S_SU: if (adv) begin
               su_q    <= stride_d;
               state_q <= S_SV;
            end
            S_SV: if (adv) begin
               line_u_q   <= left_u_q[OW-1:0];
               line_v_q   <= left_v_q[OW-1:0];
               u_stride_q <= su_q;
               v_stride_q <= stride_d;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign line_u_o   = line_u_q;
   assign line_v_o   = line_v_q;
   assign u_stride_o = u_stride_q;
   assign v_stride_o = v_stride_q;

endmodule

// File: tb/tb_mode7_line_setup.sv
// Bench for mode7_line_setup: directed cases plus random lines against an arithmetic reference model.
// Expected latency follows MODE7_SETUP_PIPE_MUL_EN.
module tb_mode7_line_setup;

`ifdef MODE7_SETUP_PIPE_MUL_EN
   localparam int LAT = 13;
`else
   localparam int LAT = 7;
`endif

   logic        clk = 1'b0;
   logic        reset, start;
   logic [28:0] a_u, a_v, b_u, b_v, c_u, c_v, d_u, d_v;
   logic [16:0] oy;
   logic        busy, done;
   logic [32:0] line_u, line_v, u_stride, v_stride;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mode7_line_setup dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .a_u_i        (a_u),
      .a_v_i        (a_v),
      .b_u_i        (b_u),
      .b_v_i        (b_v),
      .c_u_i        (c_u),
      .c_v_i        (c_v),
      .d_u_i        (d_u),
      .d_v_i        (d_v),
      .one_over_y_i (oy),
      .busy_o       (busy),
      .done_o       (done),
      .line_u_o     (line_u),
      .line_v_o     (line_v),
      .u_stride_o   (u_stride),
      .v_stride_o   (v_stride)
   );

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrapw(input longint x, input int w);
      longint t;
      t = x <<< (64 - w);
      return t >>> (64 - w);
   endfunction

   function automatic longint sx(input logic [28:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint so(input logic [32:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint edge_coord(input longint far, input longint near, input longint y);
      return wrapw(near + ((far - near) >>> 16) * y, 36);
   endfunction

   function automatic longint stride_of(input longint r, input longint l);
      return wrapw(wrapw((r - l) * 102, 45) >>> 16, 33);
   endfunction

   task automatic set_c(input longint au, input longint av, input longint bu, input longint bv,
                        input longint cu, input longint cv, input longint du, input longint dv,
                        input longint y);
      a_u = 29'(au); a_v = 29'(av); b_u = 29'(bu); b_v = 29'(bv);
      c_u = 29'(cu); c_v = 29'(cv); d_u = 29'(du); d_v = 29'(dv);
      oy  = 17'(y);
   endtask

   // Issues one start (caller sits just after a rising edge) and watches LAT+3 cycles.
   task automatic run_line(input string tag, input int restart_at, input int change_at, input int reset_at);
      longint lu, lv, ru, rv, e_lu, e_lv, e_us, e_vs;
      longint c_lu, c_lv, c_us, c_vs;
      int n_done, first;
      lu = edge_coord(sx(a_u), sx(c_u), longint'(oy));
      lv = edge_coord(sx(a_v), sx(c_v), longint'(oy));
      ru = edge_coord(sx(b_u), sx(d_u), longint'(oy));
      rv = edge_coord(sx(b_v), sx(d_v), longint'(oy));
      e_lu = wrapw(lu, 33);
      e_lv = wrapw(lv, 33);
      e_us = stride_of(ru, lu);
      e_vs = stride_of(rv, lv);
      c_lu = 0; c_lv = 0; c_us = 0; c_vs = 0;
      n_done = 0;
      first  = 0;
      start  = 1'b1;
      for (int n = 1; n <= LAT + 3; n++) begin
         @(posedge clk); #1;
         start = (n == restart_at);
         reset = (reset_at != 0) && (n == reset_at);
         if (n == change_at) begin
            a_u = ~a_u;
            a_v = ~a_v;
            oy  = ~oy;
         end
         if (n == 1) check_val({tag, ":busy_after_start"}, longint'(busy), 1);
         if (done) begin
            n_done++;
            if (first == 0) begin
               first = n;
               c_lu = so(line_u); c_lv = so(line_v);
               c_us = so(u_stride); c_vs = so(v_stride);
            end
         end
      end
      start = 1'b0;
      reset = 1'b0;
      if (reset_at == 0) begin
         check_val({tag, ":done_count"}, n_done, 1);
         check_val({tag, ":latency"}, first, LAT);
         check_val({tag, ":line_u"}, c_lu, e_lu);
         check_val({tag, ":line_v"}, c_lv, e_lv);
         check_val({tag, ":u_stride"}, c_us, e_us);
         check_val({tag, ":v_stride"}, c_vs, e_vs);
         check_val({tag, ":hold_line_u"}, so(line_u), e_lu);
         check_val({tag, ":hold_v_stride"}, so(v_stride), e_vs);
      end else begin
         check_val({tag, ":done_count"}, n_done, 0);
         check_val({tag, ":line_u"}, so(line_u), 0);
         check_val({tag, ":u_stride"}, so(u_stride), 0);
      end
      check_val({tag, ":busy_idle"}, longint'(busy), 0);
   endtask

   task automatic set_basic(input longint sgn);
      set_c(sgn * (100 <<< 16), 0, sgn * (740 <<< 16), 0, 0, 0, sgn * (640 <<< 16), 0, 65536);
   endtask

   initial begin
      int cnt;
      longint r;
      reset = 1'b1;
      start = 1'b0;
      set_c(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check_val("rst:busy", longint'(busy), 0);
      check_val("rst:done", longint'(done), 0);
      check_val("rst:line_u", so(line_u), 0);
      check_val("rst:line_v", so(line_v), 0);
      check_val("rst:u_stride", so(u_stride), 0);
      check_val("rst:v_stride", so(v_stride), 0);

      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      check_val("idle:no_done", cnt, 0);

      set_basic(1);
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      check_val("rst_start:busy", longint'(busy), 0);
      cnt = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      check_val("rst_start:no_done", cnt, 0);

      set_basic(1);
      run_line("basic", 0, 0, 0);
      check_val("basic:const_line_u", so(line_u), 6553600);
      check_val("basic:const_u_stride", so(u_stride), 65280);
      check_val("basic:const_line_v", so(line_v), 0);
      check_val("basic:const_v_stride", so(v_stride), 0);

      set_basic(-1);
      run_line("neg", 0, 0, 0);
      check_val("neg:const_line_u", so(line_u), -6553600);
      check_val("neg:const_u_stride", so(u_stride), -65280);

      set_basic(1);
      c_u = 29'(1 <<< 16);
      a_u = 29'(201 <<< 16);
      oy  = 17'd32768;
      run_line("half", 0, 0, 0);
      check_val("half:const_line_u", so(line_u), 6619136);

      set_c(-123456, 98765, 5555555, -4444444, 3000000, -7000000, -2000000, 1234567, 0);
      run_line("oy0", 0, 0, 0);
      check_val("oy0:line_is_c_u", so(line_u), -3000000 + 6000000);
      check_val("oy0:line_is_c_v", so(line_v), -7000000);

      set_basic(1);
      run_line("restart", 3, 0, 0);
      set_c(77 <<< 16, -5 <<< 16, 900 <<< 16, 12 <<< 16, 3 <<< 16, 1 <<< 16, 500 <<< 16, -8 <<< 16, 40000);
      run_line("latch", 0, 1, 0);

      set_basic(1);
      run_line("mid_reset", 0, 0, 4);
      set_basic(-1);
      run_line("after_reset", 0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         set_c(longint'(29'($urandom)), longint'(29'($urandom)), longint'(29'($urandom)),
               longint'(29'($urandom)), longint'(29'($urandom)), longint'(29'($urandom)),
               longint'(29'($urandom)), longint'(29'($urandom)), 0);
         r = longint'($urandom_range(0, 3));
         if (r == 0)      oy = 17'd0;
         else if (r == 1) oy = 17'd65536;
         else             oy = 17'($urandom_range(0, 65536));
         run_line($sformatf("rand%0d", i), (i % 4 == 1) ? 2 : 0, (i % 4 == 2) ? 1 : 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
